counter_64_bit_arbiter: RTL and testbench
=========================================

COUNTER_64_BIT_ARBITER -- requirements
Module: counter_64_bit_arbiter

Interface
REQ-001 Parameter: WIDTH, default 64, counter data width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 r0_valid  input  1  requester 0 command valid.
REQ-005 r0_op  input  2  requester 0 opcode: 0 LOAD, 1 RUN, 2 STOP, 3 READ.
REQ-006 r0_data  input  WIDTH  requester 0 load value; ignored for ops other than LOAD.
REQ-007 r0_ready  output  1  requester 0 command accepted when r0_valid && r0_ready.
REQ-008 r1_valid, r1_op, r1_data, r1_ready: same directions, widths and meanings as the r0_* ports, for requester 1.
REQ-009 rsp_valid  output  1  response valid.
REQ-010 rsp_id  output  1  index of the requester that owns the response.
REQ-011 rsp_data  output  WIDTH  counter value captured for the response.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-013 load  output  1  one-cycle load strobe to the counter.
REQ-014 din  output  WIDTH  load value to the counter.
REQ-015 wen  output  1  counter count-enable level.
REQ-016 q  input  WIDTH  current counter value.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-018 In IDLE, ready SHALL be asserted only to the arbitration winner, combinationally from the valids; the loser's ready and both readies outside IDLE SHALL be 0.
REQ-019 Arbitration SHALL be round-robin: the winner is the requester indicated by a 1-bit priority pointer, or the other requester if the pointed one is not valid.
REQ-020 On a handshake in IDLE, the block SHALL latch op, data and id, SHALL set the pointer to the non-granted requester, and SHALL move to EXEC.
REQ-021 With no valid in IDLE, the block SHALL stay in IDLE and SHALL leave the pointer unchanged.
REQ-022 EXEC SHALL last exactly one cycle, then move to RESP.
REQ-023 In EXEC with op LOAD, load SHALL be 1 and din SHALL equal the latched data for that cycle only; load SHALL be 0 in every other cycle.
REQ-024 In EXEC, op RUN SHALL set wen to 1 and op STOP SHALL clear it, effective from the next cycle; LOAD and READ SHALL leave wen unchanged.
REQ-025 In EXEC, rsp_data SHALL capture q for every op; this is the pre-update counter value for LOAD.
REQ-026 In RESP, rsp_valid SHALL be 1 and rsp_id and rsp_data SHALL be held stable until rsp_ready.
REQ-027 On rsp_valid && rsp_ready, the block SHALL return to IDLE; a new grant SHALL NOT occur in that same cycle.
REQ-028 Minimum command-to-command spacing SHALL be 3 cycles: accept, EXEC, RESP with rsp_ready high.
REQ-029 RUN while already running and STOP while already stopped SHALL be legal, SHALL leave wen unchanged, and SHALL still respond.
REQ-030 din SHALL hold its last driven value when load is 0.
REQ-031 A requester that deasserts valid before being granted SHALL lose no state; nothing is latched without a handshake.

Reset
REQ-032 Asserting rst SHALL force IDLE, pointer=0 (requester 0 favoured), wen=0, load=0, din=0, rsp_valid=0, rsp_id=0, rsp_data=0 immediately, without waiting for a clock edge.
REQ-033 A command in EXEC or RESP when rst asserts SHALL be discarded with no response and no load strobe.
REQ-034 The first grant after rst deassertion SHALL be possible on the first clock edge.

Verification
REQ-035 After reset, r0 issues LOAD data=0x0000_0000_0000_00FF -> r0_ready=1 in IDLE; next cycle load=1, din=0xFF; following cycle rsp_valid=1, rsp_id=0.
REQ-036 r0 and r1 both valid with op READ continuously, rsp_ready=1 -> grants alternate r0, r1, r0, r1, one grant every 3 cycles; rsp_id alternates 0,1,0,1.
REQ-037 r1 RUN, then r0 READ with q driven to 0x10 during EXEC -> wen=1 from the cycle after r1's EXEC; r0 response has rsp_data=0x10.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable all 5 cycles; both readies 0; no load pulse.
REQ-039 rst asserted mid-cycle while in EXEC with op LOAD -> load, wen and rsp_valid drop to 0 before the next edge; no response after reset; the next grant goes to r0 if both valid.
REQ-040 STOP issued while wen=0 -> wen stays 0 and one response is produced.

Source files
------------

// File: rtl/counter_64_bit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : counter_64_bit_arbiter
// Brief   : Round-robin two-requester command front end for a loadable counter.
// Revision: 1.0
// ============================================================================
module counter_64_bit_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  input  logic [1:0]       r0_op,
  input  logic [WIDTH-1:0] r0_data,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [1:0]       r1_op,
  input  logic [WIDTH-1:0] r1_data,
  output logic             r1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             load,
  output logic [WIDTH-1:0] din,
  output logic             wen,
  input  logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STOP = 2'd2;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [1:0]         op_q, op_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   din_q, din_d;
  logic               wen_q, wen_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic               grant0, grant1;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_data;

  // The pointed requester wins; the other one wins only when the pointed one is idle.
  assign grant0   = r0_valid && (!ptr_q || !r1_valid);
  assign grant1   = r1_valid && ( ptr_q || !r0_valid);
  assign r0_ready = (state_q == IDLE) && grant0;
  assign r1_ready = (state_q == IDLE) && grant1;
  assign sel_op   = grant1 ? r1_op   : r0_op;
  assign sel_data = grant1 ? r1_data : r0_data;

  assign load      = (state_q == EXEC) && (op_q == OP_LOAD);
  assign din       = din_q;
  assign wen       = wen_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    id_d       = id_q;
    din_d      = din_q;
    wen_d      = wen_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (r0_ready || r1_ready) begin
          op_d    = sel_op;
          id_d    = grant1;
          ptr_d   = !grant1;
          state_d = EXEC;
          // din only moves for LOAD so it keeps its last driven value otherwise.
          if (sel_op == OP_LOAD) begin
            din_d = sel_data;
          end
        end
      end
      EXEC: begin
        rsp_data_d = q;
        if (op_q == OP_RUN) begin
          wen_d = 1'b1;
        end else if (op_q == OP_STOP) begin
          wen_d = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      op_q       <= 2'd0;
      id_q       <= 1'b0;
      din_q      <= '0;
      wen_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      id_q       <= id_d;
      din_q      <= din_d;
      wen_q      <= wen_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_64_bit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_64_bit_arbiter
// Brief   : Directed self-checking bench for counter_64_bit_arbiter.
// Revision: 1.0
// ============================================================================
module tb_counter_64_bit_arbiter;

  localparam int WIDTH = 64;

  logic             clk;
  logic             rst;
  logic             r0_valid, r1_valid;
  logic [1:0]       r0_op, r1_op;
  logic [WIDTH-1:0] r0_data, r1_data;
  logic             r0_ready, r1_ready;
  logic             rsp_valid, rsp_id, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             load, wen;
  logic [WIDTH-1:0] din, q;

  int checks = 0;
  int errors = 0;

  counter_64_bit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_op(r0_op), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_op(r1_op), .r1_data(r1_data), .r1_ready(r1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .load(load), .din(din), .wen(wen), .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later still.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; r0_valid = 0; r1_valid = 0; r0_op = 0; r1_op = 0;
    r0_data = '0; r1_data = '0; rsp_ready = 1'b1; q = '0;
    tick(); tick();
    #1;
    checks++;
    if ({load, wen, rsp_valid, rsp_id, r0_ready, r1_ready} !== 6'b0 || din !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_state: load=%b wen=%b rsp_valid=%b rsp_id=%b rdy=%b%b din=%h rsp_data=%h, required all 0",
               load, wen, rsp_valid, rsp_id, r0_ready, r1_ready, din, rsp_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load();
    r0_valid = 1; r0_op = 2'd0; r0_data = 64'hFF; q = 64'h55;
    #1;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL load_grant: r0_ready=%b r1_ready=%b, required 1 0", r0_ready, r1_ready);
    end
    tick(); r0_valid = 0; #1;
    checks++;
    if (load !== 1'b1 || din !== 64'hFF || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL load_exec: load=%b din=%h rsp_valid=%b, required 1 ff 0", load, din, rsp_valid);
    end
    tick(); #1;
    checks++;
    if (load !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'h55 || din !== 64'hFF) begin
      errors++; $display("FAIL load_resp: load=%b rsp_valid=%b rsp_id=%b rsp_data=%h din=%h, required 0 1 0 55 ff",
                         load, rsp_valid, rsp_id, rsp_data, din);
    end
    tick(); #1;
    checks++;
    if (rsp_valid !== 1'b0 || wen !== 1'b0) begin
      errors++; $display("FAIL load_done: rsp_valid=%b wen=%b, required 0 0", rsp_valid, wen);
    end
  endtask

  // Pointer is 1 after r0's LOAD, so the sequence starts with r1.
  task automatic test_round_robin();
    logic exp_id;
    exp_id = 1'b1;
    r0_valid = 1; r1_valid = 1; r0_op = 2'd3; r1_op = 2'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (r0_ready !== !exp_id || r1_ready !== exp_id) begin
        errors++; $display("FAIL rr_grant%0d: r0_ready=%b r1_ready=%b, required %b %b", i, r0_ready, r1_ready, !exp_id, exp_id);
      end
      tick(); q = 64'h100 + 64'(i); #1;
      checks++;
      if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || load !== 1'b0) begin
        errors++; $display("FAIL rr_exec%0d: rdy=%b%b load=%b, required 00 0", i, r0_ready, r1_ready, load);
      end
      tick(); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== 64'h100 + 64'(i) || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        errors++; $display("FAIL rr_resp%0d: rsp_valid=%b rsp_id=%b rsp_data=%h rdy=%b%b, required 1 %b %h 00",
                           i, rsp_valid, rsp_id, rsp_data, r0_ready, r1_ready, exp_id, 64'h100 + 64'(i));
      end
      tick();
      exp_id = !exp_id;
    end
    r0_valid = 0; r1_valid = 0;
  endtask

  task automatic test_run_read();
    r1_valid = 1; r1_op = 2'd1;
    tick(); r1_valid = 0; #1;
    checks++;
    if (wen !== 1'b0) begin
      errors++; $display("FAIL run_exec_wen: wen=%b, required 0", wen);
    end
    tick(); #1;
    checks++;
    if (wen !== 1'b1 || rsp_id !== 1'b1 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL run_resp: wen=%b rsp_id=%b rsp_valid=%b, required 1 1 1", wen, rsp_id, rsp_valid);
    end
    tick();
    r0_valid = 1; r0_op = 2'd3;
    tick(); r0_valid = 0; q = 64'h10;
    tick(); #1;
    checks++;
    if (rsp_data !== 64'h10 || rsp_id !== 1'b0 || wen !== 1'b1) begin
      errors++; $display("FAIL read_resp: rsp_data=%h rsp_id=%b wen=%b, required 10 0 1", rsp_data, rsp_id, wen);
    end
    tick();
  endtask

  task automatic test_stall();
    r1_valid = 1; r1_op = 2'd3;
    tick(); r1_valid = 0; q = 64'hABCD; rsp_ready = 0;
    tick();
    r0_valid = 1; r1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      q = 64'h9000 + 64'(i);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 64'hABCD ||
          r0_ready !== 1'b0 || r1_ready !== 1'b0 || load !== 1'b0) begin
        errors++; $display("FAIL stall%0d: rsp_valid=%b rsp_id=%b rsp_data=%h rdy=%b%b load=%b, required 1 1 abcd 00 0",
                           i, rsp_valid, rsp_id, rsp_data, r0_ready, r1_ready, load);
      end
      tick();
    end
    rsp_ready = 1; #1;
    checks++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL stall_release_no_grant: rdy=%b%b, required 00", r0_ready, r1_ready);
    end
    tick(); #1;
    checks++;
    if (rsp_valid !== 1'b0 || r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL stall_idle: rsp_valid=%b rdy=%b%b, required 0 10", rsp_valid, r0_ready, r1_ready);
    end
    r0_valid = 0; r1_valid = 0;
  endtask

  task automatic test_stop();
    r0_valid = 1; r0_op = 2'd2;
    tick(); r0_valid = 0;
    tick(); #1;
    checks++;
    if (wen !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL stop_resp: wen=%b rsp_valid=%b rsp_id=%b, required 0 1 0", wen, rsp_valid, rsp_id);
    end
    tick();
    r1_valid = 1; r1_op = 2'd2;
    tick(); r1_valid = 0;
    tick(); #1;
    checks++;
    if (wen !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL stop_idle_resp: wen=%b rsp_valid=%b rsp_id=%b, required 0 1 1", wen, rsp_valid, rsp_id);
    end
    tick(); #1;
    checks++;
    if (rsp_valid !== 1'b0 || wen !== 1'b0) begin
      errors++; $display("FAIL stop_single_resp: rsp_valid=%b wen=%b, required 0 0", rsp_valid, wen);
    end
    tick(); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stop_no_extra_resp: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_reset_exec();
    r0_valid = 1; r0_op = 2'd1;
    tick(); r0_valid = 0;
    tick(); tick();
    r1_valid = 1; r1_op = 2'd0; r1_data = 64'h1234;
    tick(); r1_valid = 0; #1;
    checks++;
    if (load !== 1'b1 || wen !== 1'b1 || din !== 64'h1234) begin
      errors++; $display("FAIL rst_pre: load=%b wen=%b din=%h, required 1 1 1234", load, wen, din);
    end
    #1 rst = 1'b1; #1;
    checks++;
    if (load !== 1'b0 || wen !== 1'b0 || rsp_valid !== 1'b0 || din !== '0) begin
      errors++; $display("FAIL rst_async: load=%b wen=%b rsp_valid=%b din=%h, required 0 0 0 0", load, wen, rsp_valid, din);
    end
    tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || load !== 1'b0) begin
        errors++; $display("FAIL rst_no_resp%0d: rsp_valid=%b load=%b, required 0 0", i, rsp_valid, load);
      end
    end
    r0_valid = 1; r1_valid = 1; r0_op = 2'd3; r1_op = 2'd3; #1;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL rst_next_grant: rdy=%b%b, required 10", r0_ready, r1_ready);
    end
    tick(); r0_valid = 0; r1_valid = 0;
    tick(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL rst_next_resp: rsp_valid=%b rsp_id=%b, required 1 0", rsp_valid, rsp_id);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_round_robin();
    test_run_read();
    test_stall();
    test_stop();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
